priority_encoder8_seq: RTL and testbench
========================================

// Module: priority_encoder8_seq
// PURPOSE
//   Sequential 8-to-3 encoder; inverse direction of the 3-to-8 decoder in the ALU/decode lab datapath.
//   Accepts an 8-bit request vector, then emits the 3-bit index of every set bit, one code per handshake.
//   Default order is highest index first. A zero vector is flagged as an error.
//   Sits between request sources (interrupt lines, bus grants) and any consumer of 3-bit select codes.
// PARAMETERS
//   N_IN    8  request vector width (fixed at 8 for this block)
//   CODE_W  3  code width = clog2(N_IN)
// PORTS
//   clk         in   1       rising-edge clock; single clock domain
//   rst         in   1       synchronous reset, active-high
//   E           in   1       enable; 0 freezes the block (same role as decoder enable)
//   req_valid   in   1       request vector y is valid
//   req_ready   out  1       block can accept a vector
//   y           in   8       request vector; bit i set = request i
//   code_valid  out  1       W holds a valid code
//   code_ready  in   1       consumer accepts W this cycle
//   W           out  3       encoded index, W[2] = MSB
//   last        out  1       current code is the final one for the captured vector
//   err         out  1       one-cycle pulse: a zero vector was accepted
// BEHAVIOUR
//   - Reset (rst=1 at a clk edge): state=IDLE, pend=8'h00, W=3'b000, code_valid=0, last=0, err=0.
//     Under PENC_RR_EN, ptr=3'd7.
//   - rst has priority over every other input. Mid-burst reset drops the remaining pending bits.
//   - FSM states: IDLE, BUSY.
//     - IDLE: req_ready = E.
//     - IDLE, E & req_valid, y != 0: pend <= y; go to BUSY next cycle.
//     - IDLE, E & req_valid, y == 0: err=1 for exactly the next cycle; stay IDLE; no code is emitted.
//     - BUSY: req_ready=0.
//       - code_valid = E.
//       - W = selected index of pend (combinational from the pend/ptr registers).
//       - last = (pend has exactly one bit set).
//     - BUSY, E & code_ready: clear pend[W]. If that bit was the last one, go to IDLE next cycle;
//       otherwise stay in BUSY with the next index.
//   - Latency: vector accepted at edge k -> first code_valid in cycle k+1. One code per cycle at full throughput.
//     After the final handshake, req_ready rises the next cycle (no accept-on-last overlap).
//   - Backpressure: while code_valid=1 and code_ready=0, W and last are held stable.
//   - E=0: no state change, no handshakes; req_ready=0 and code_valid=0. pend and state are retained.
//     With E=1 the block resumes at the same code.
//   - y is ignored outside of an accepted request. err is never asserted in BUSY.
//   - W=3'b000 whenever code_valid=0 (outputs are deterministic).
// CONFIGURATION
//   PENC_RR_EN undefined: fixed priority; the search runs 7 down to 0 and the highest set bit is selected.
//   PENC_RR_EN defined: rotating priority across vectors.
//     - 3-bit ptr; the search runs ptr, ptr-1, ... and wraps mod 8.
//     - After each code handshake with code c: ptr <= c-1 mod 8.
//     - ptr survives between vectors; only rst sets it back to 7.
// TESTING
//   1 Reset: rst=1 for 2 cycles, E=1 -> req_ready=1, code_valid=0, W=000, last=0, err=0.
//   2 Burst: y=8'b1010_0100, code_ready=1 held -> W=7,5,2 in consecutive cycles.
//     last=1 only with W=2; req_ready=1 the following cycle.
//   3 Backpressure: y=8'h01, code_ready=0 for 3 cycles -> W=000, code_valid=1, last=1 stable.
//     Handshake on code_ready=1, then IDLE.
//   4 Zero vector: y=8'h00 accepted -> err=1 for one cycle; code_valid stays 0; req_ready stays 1.
//   5 Enable/reset mid-op: y=8'hC0, after W=7 accepted drop E for 2 cycles -> no activity, then W=6.
//     Separately, rst during BUSY -> IDLE, pend=0, next vector processed normally.
//   6 PENC_RR_EN: y=8'h10 -> W=4 (ptr becomes 3); then y=8'h22 -> W=1 then W=5.
//     Without the macro, the same second vector gives W=5 then W=1.

Source files
------------

// File: rtl/priority_encoder8_seq.sv
// -----------------------------------------------------------------------------
// priority_encoder8_seq
//
// Sequential 8-to-3 priority encoder. A non-zero request vector is captured
// with a valid/ready handshake. The block then emits the 3-bit index of each
// set bit, one code per consumer handshake. A zero vector produces a
// one-cycle err pulse and no codes.
//
// Search order:
//   PENC_RR_EN undefined : fixed priority, highest set index first (7 -> 0).
//   PENC_RR_EN defined   : rotating priority. The search starts at ptr and
//                          runs downward, wrapping mod 8. After every code
//                          handshake with code c, ptr becomes c-1. ptr is
//                          carried across vectors and is only reset by rst.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous reset, active-high, overrides everything
//   E          in   enable; 0 freezes state and suppresses all handshakes
//   req_valid  in   request vector y is valid
//   req_ready  out  block can accept a vector (IDLE and E)
//   y          in   request vector, bit i set = request i
//   code_valid out  W holds a valid code (BUSY and E)
//   code_ready in   consumer accepts W this cycle
//   W          out  encoded index (000 whenever code_valid=0)
//   last       out  current code is the final one of the captured vector
//   err        out  one-cycle pulse after a zero vector was accepted
// -----------------------------------------------------------------------------
module priority_encoder8_seq #(
    parameter int N_IN   = 8,
    parameter int CODE_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              E,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [N_IN-1:0]   y,
    output logic              code_valid,
    input  logic              code_ready,
    output logic [CODE_W-1:0] W,
    output logic              last,
    output logic              err
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t            state_reg, state_next;
    logic [N_IN-1:0]   pend_reg, pend_next;
    logic              err_reg, err_next;

    // Index at which the downward search starts.
    logic [CODE_W-1:0] search_base;

`ifdef PENC_RR_EN
    logic [CODE_W-1:0] ptr_reg, ptr_next;
    assign search_base = ptr_reg;
`else
    assign search_base = CODE_W'(N_IN - 1);
`endif

    // Pending vector rotated so that rot[k] is the bit visited k steps into
    // the search. The CODE_W-bit subtraction provides the mod-8 wrap.
    logic [N_IN-1:0] rot;

    genvar gi;
    generate
        for (gi = 0; gi < N_IN; gi++) begin : g_rot
            assign rot[gi] = pend_reg[search_base - CODE_W'(gi)];
        end
    endgenerate

    // First set bit in search order.
    logic [CODE_W-1:0] sel_off;
    logic              sel_found;
    logic [CODE_W-1:0] sel_code;

    always_comb begin
        sel_off   = '0;
        sel_found = 1'b0;
        for (int k = 0; k < N_IN; k++) begin
            if (!sel_found && rot[k]) begin
                sel_off   = CODE_W'(k);
                sel_found = 1'b1;
            end
        end
    end

    assign sel_code = search_base - sel_off;

    // Exactly one bit pending (pend is never zero while BUSY).
    logic pend_single;
    assign pend_single = (pend_reg & (pend_reg - N_IN'(1))) == '0;

    // Handshake-facing outputs are derived from registered state only,
    // gated by E so a frozen block shows no activity.
    logic busy;
    logic accept;
    logic handshake;

    assign busy       = (state_reg == BUSY);
    assign req_ready  = E & ~busy;
    assign code_valid = E & busy;
    assign W          = code_valid ? sel_code : '0;
    assign last       = code_valid & pend_single;
    assign err        = err_reg;

    assign accept     = req_ready & req_valid;
    assign handshake  = code_valid & code_ready;

    logic [N_IN-1:0] clear_mask;
    assign clear_mask = N_IN'(1) << sel_code;

    always_comb begin
        state_next = state_reg;
        pend_next  = pend_reg;
        err_next   = 1'b0;
`ifdef PENC_RR_EN
        ptr_next   = ptr_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (y != '0) begin
                        pend_next  = y;
                        state_next = BUSY;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (handshake) begin
                    pend_next = pend_reg & ~clear_mask;
                    // No accept-on-last overlap: return to IDLE first and
                    // offer req_ready only from the following cycle.
                    if (pend_single) begin
                        state_next = IDLE;
                    end
`ifdef PENC_RR_EN
                    ptr_next = sel_code - CODE_W'(1);
`endif
                end
            end
            default: begin
                state_next = IDLE;
                pend_next  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            pend_reg  <= '0;
            err_reg   <= 1'b0;
`ifdef PENC_RR_EN
            ptr_reg   <= CODE_W'(N_IN - 1);
`endif
        end else begin
            state_reg <= state_next;
            pend_reg  <= pend_next;
            err_reg   <= err_next;
`ifdef PENC_RR_EN
            ptr_reg   <= ptr_next;
`endif
        end
    end

endmodule

// File: tb/tb_priority_encoder8_seq.sv
// -----------------------------------------------------------------------------
// tb_priority_encoder8_seq
//
// Self-checking bench for priority_encoder8_seq. Inputs are driven on the
// falling edge, outputs are sampled 1 ns later, state advances on the rising
// edge. Expected code sequences come from a reference model that scans the
// captured vector bit by bit in the documented search order.
// -----------------------------------------------------------------------------
module tb_priority_encoder8_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       E;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] y;
    logic       code_valid;
    logic       code_ready;
    logic [2:0] W;
    logic       last;
    logic       err;

    int checks   = 0;
    int failures = 0;

    // Reference model state.
    int model_ptr = 7;
    int exp_q[$];

    always #5 clk = ~clk;

    priority_encoder8_seq dut (
        .clk        (clk),
        .rst        (rst),
        .E          (E),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .y          (y),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .W          (W),
        .last       (last),
        .err        (err)
    );

    // Returns the first set index found when walking down from base, mod 8.
    function automatic int pick(input logic [7:0] p, input int base);
        for (int k = 0; k < 8; k++) begin
            int idx;
            idx = (base - k + 8) % 8;
            if (p[idx]) return idx;
        end
        return -1;
    endfunction

    // Fills exp_q with the full code order for vector v.
    function automatic void build_expected(input logic [7:0] v);
        logic [7:0] p;
        int c;
        p = v;
        exp_q.delete();
        while (p != 8'h00) begin
`ifdef PENC_RR_EN
            c = pick(p, model_ptr);
            model_ptr = (c + 7) % 8;
`else
            c = pick(p, 7);
`endif
            exp_q.push_back(c);
            p[c] = 1'b0;
        end
    endfunction

    // Offers vector v for one cycle in IDLE with E=1.
    task automatic drive_accept(input logic [7:0] v, input string name);
        logic [6:0] obs;
        @(negedge clk);
        E = 1'b1; req_valid = 1'b1; y = v; code_ready = 1'($urandom);
        #1;
        obs = {req_ready, code_valid, W, last, err};
        checks++;
        if (obs[6:5] !== 2'b10) begin
            failures++;
            $display("FAIL %s_accept: {req_ready,code_valid}=%b expected 10", name, obs[6:5]);
        end
        @(posedge clk);
    endtask

    // Walks exp_q to completion with random stalls and enable drops, then
    // checks the block is back in IDLE.
    task automatic drain(input string name, input int stall_pct, input int e_drop_pct);
        logic [6:0] obs;
        logic [6:0] exp;
        int budget;
        budget = 400;
        while (exp_q.size() > 0 && budget > 0) begin
            @(negedge clk);
            req_valid  = 1'($urandom);
            y          = 8'($urandom);
            E          = ($urandom_range(99) >= e_drop_pct);
            code_ready = ($urandom_range(99) >= stall_pct);
            #1;
            obs = {req_ready, code_valid, W, last, err};
            if (E) exp = {1'b0, 1'b1, 3'(exp_q[0]), (exp_q.size() == 1), 1'b0};
            else   exp = 7'b0;
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL %s_code: {rr,cv,W,last,err}=%b expected %b", name, obs, exp);
            end
            @(posedge clk);
            if (E && code_ready) void'(exp_q.pop_front());
            budget--;
        end
        if (budget == 0) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: %0d codes left expected 0", name, exp_q.size());
        end
        @(negedge clk);
        E = 1'b1; req_valid = 1'b0; code_ready = 1'b0;
        #1;
        obs = {req_ready, code_valid, W, last, err};
        checks++;
        if (obs !== 7'b1000000) begin
            failures++;
            $display("FAIL %s_idle: {rr,cv,W,last,err}=%b expected 1000000", name, obs);
        end
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        rst = 1'b1; E = 1'b1; req_valid = 1'b0; code_ready = 1'b0; y = 8'h00;
        repeat (cycles) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_ptr = 7;
        exp_q.delete();
    endtask

    task automatic test_reset();
        logic [6:0] obs;
        rst = 1'b1; E = 1'b1; req_valid = 1'b0; code_ready = 1'b0; y = 8'h00;
        do_reset(2);
        #1;
        obs = {req_ready, code_valid, W, last, err};
        checks++;
        if (obs !== 7'b1000000) begin
            failures++;
            $display("FAIL reset: {rr,cv,W,last,err}=%b expected 1000000", obs);
        end
    endtask

    task automatic test_burst();
        drive_accept(8'hA4, "burst");
        build_expected(8'hA4);
        drain("burst", 0, 0);
    endtask

    task automatic test_backpressure();
        logic [6:0] obs;
        logic [6:0] exp;
        drive_accept(8'h01, "bp");
        build_expected(8'h01);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            req_valid = 1'b0; code_ready = 1'b0; E = 1'b1;
            #1;
            obs = {req_ready, code_valid, W, last, err};
            exp = {1'b0, 1'b1, 3'(exp_q[0]), 1'b1, 1'b0};
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL bp_hold%0d: {rr,cv,W,last,err}=%b expected %b", i, obs, exp);
            end
            @(posedge clk);
        end
        drain("bp", 0, 0);
    endtask

    task automatic test_zero();
        logic [6:0] obs;
        drive_accept(8'h00, "zero");
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        obs = {req_ready, code_valid, W, last, err};
        checks++;
        if (obs !== 7'b1000001) begin
            failures++;
            $display("FAIL zero_err: {rr,cv,W,last,err}=%b expected 1000001", obs);
        end
        @(negedge clk);
        #1;
        obs = {req_ready, code_valid, W, last, err};
        checks++;
        if (obs !== 7'b1000000) begin
            failures++;
            $display("FAIL zero_pulse_end: {rr,cv,W,last,err}=%b expected 1000000", obs);
        end
    endtask

    task automatic test_enable();
        logic [6:0] obs;
        logic [6:0] exp;
        drive_accept(8'hC0, "enable");
        build_expected(8'hC0);
        @(negedge clk);
        req_valid = 1'b0; code_ready = 1'b1; E = 1'b1;
        #1;
        obs = {req_ready, code_valid, W, last, err};
        exp = {1'b0, 1'b1, 3'(exp_q[0]), 1'b0, 1'b0};
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL enable_first: {rr,cv,W,last,err}=%b expected %b", obs, exp);
        end
        @(posedge clk);
        void'(exp_q.pop_front());
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            E = 1'b0; code_ready = 1'b1; req_valid = 1'b1;
            #1;
            obs = {req_ready, code_valid, W, last, err};
            checks++;
            if (obs !== 7'b0000000) begin
                failures++;
                $display("FAIL enable_frozen%0d: {rr,cv,W,last,err}=%b expected 0000000", i, obs);
            end
            @(posedge clk);
        end
        drain("enable", 0, 0);
    endtask

    task automatic test_reset_mid();
        logic [6:0] obs;
        logic [6:0] exp;
        drive_accept(8'hA5, "rstmid");
        build_expected(8'hA5);
        @(negedge clk);
        req_valid = 1'b0; code_ready = 1'b1; E = 1'b1;
        #1;
        obs = {req_ready, code_valid, W, last, err};
        exp = {1'b0, 1'b1, 3'(exp_q[0]), 1'b0, 1'b0};
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL rstmid_first: {rr,cv,W,last,err}=%b expected %b", obs, exp);
        end
        @(posedge clk);
        do_reset(1);
        #1;
        obs = {req_ready, code_valid, W, last, err};
        checks++;
        if (obs !== 7'b1000000) begin
            failures++;
            $display("FAIL rstmid_idle: {rr,cv,W,last,err}=%b expected 1000000", obs);
        end
        drive_accept(8'h3C, "rstmid_next");
        build_expected(8'h3C);
        drain("rstmid_next", 30, 10);
    endtask

    // Explicit rotating/fixed order check from reset: 0x10 then 0x22.
    task automatic test_order();
        logic [6:0] obs;
        logic [6:0] exp;
        logic [7:0] vecs[2];
        int want[3];
        int idx;
        int n;
        vecs = '{8'h10, 8'h22};
`ifdef PENC_RR_EN
        want = '{4, 1, 5};
`else
        want = '{4, 5, 1};
`endif
        do_reset(2);
        idx = 0;
        for (int v = 0; v < 2; v++) begin
            drive_accept(vecs[v], "order");
            build_expected(vecs[v]);
            n = $countones(vecs[v]);
            for (int j = 0; j < n; j++) begin
                @(negedge clk);
                req_valid = 1'b0; code_ready = 1'b1; E = 1'b1;
                #1;
                obs = {req_ready, code_valid, W, last, err};
                exp = {1'b0, 1'b1, 3'(want[idx]), (j == n - 1), 1'b0};
                checks++;
                if (obs !== exp) begin
                    failures++;
                    $display("FAIL order_code%0d: {rr,cv,W,last,err}=%b expected %b", idx, obs, exp);
                end
                @(posedge clk);
                idx++;
            end
            exp_q.delete();
            @(negedge clk);
            #1;
            obs = {req_ready, code_valid, W, last, err};
            checks++;
            if (obs !== 7'b1000000) begin
                failures++;
                $display("FAIL order_idle%0d: {rr,cv,W,last,err}=%b expected 1000000", v, obs);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] v;
        for (int i = 0; i < 30; i++) begin
            v = 8'($urandom);
            if (i % 10 == 9) v = 8'h00;
            if (v == 8'h00) begin
                test_zero();
            end else begin
                drive_accept(v, "random");
                build_expected(v);
                drain("random", 40, 15);
            end
        end
    endtask

    initial begin
        test_reset();
        test_burst();
        test_backpressure();
        test_zero();
        test_enable();
        test_reset_mid();
        test_order();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
